clock_div_multi: RTL and testbench

Parametrised multi-channel clock divider that replaces the single fixed-ratio divider. It generates `NUM_CH` independent 50%-duty divided clocks, each with a single-cycle `tick` strobe coincident with every toggle. Each channel has a runtime-loadable half-period applied glitch-free at the channel's next terminal count. It sits beside the board clock and feeds display-anode scanning, LED chase stepping and other slow-rate logic; downstream logic uses `tick` as an enable in the `clk` domain.

---
 rtl/clock_div_multi.sv | 109 ++++++++++
 tb/tb_clock_div_multi.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/clock_div_multi.sv
// Multi-channel 50%-duty clock divider with per-channel tick strobes and shadowed half-period loads.
// Optional CLOCK_DIV_MULTI_SYNC_EN adds a `sync` input that phase-aligns every channel.
module clock_div_multi #(
    parameter  int NUM_CH       = 4,
    parameter  int CNT_W        = 27,
    parameter  int DEFAULT_HALF = 90_000,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
`ifdef CLOCK_DIV_MULTI_SYNC_EN
    input  logic              sync,
`endif
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] div_clk,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] pend_v;
    logic              sync_i;

`ifdef CLOCK_DIV_MULTI_SYNC_EN
    assign sync_i = sync;
`else
    assign sync_i = 1'b0;
`endif

    // Out-of-range channels match no entry, so they stay ready and the load is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) cfg_ready = ~pend_v[i];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] half;
        logic [CNT_W-1:0] shadow;
        logic [CNT_W-1:0] h_eff;
        logic             pend;
        logic             div_q;
        logic             tick_q;
        logic             term;
        logic             xfer;

        assign h_eff = (half == '0) ? CNT_W'(1) : half;
        // >= rather than == so a half shrunk below a frozen count cannot wrap the counter.
        assign term  = (cnt >= h_eff - CNT_W'(1));
        assign xfer  = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt    <= '0;
                half   <= CNT_W'(DEFAULT_HALF);
                shadow <= CNT_W'(DEFAULT_HALF);
                pend   <= 1'b0;
                div_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (sync_i) begin
                cnt    <= '0;
                div_q  <= 1'b0;
                tick_q <= 1'b0;
                pend   <= 1'b0;
                if (xfer) begin
                    shadow <= cfg_half;
                    half   <= cfg_half;
                end else if (pend) begin
                    half   <= shadow;
                end
            end else begin
                if (en[g]) begin
                    if (term) begin
                        cnt    <= '0;
                        div_q  <= ~div_q;
                        tick_q <= 1'b1;
                        if (pend) begin
                            half <= shadow;
                            pend <= 1'b0;
                        end
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                        tick_q <= 1'b0;
                    end
                end else begin
                    tick_q <= 1'b0;
                    if (pend) begin
                        half <= shadow;
                        pend <= 1'b0;
                    end
                end
                // A transfer only happens while pend is clear, so it never collides with an apply.
                if (xfer) begin
                    shadow <= cfg_half;
                    pend   <= 1'b1;
                end
            end
        end

        assign div_clk[g] = div_q;
        assign tick[g]    = tick_q;
        assign pend_v[g]  = pend;
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed bench for clock_div_multi (3 channels, 8-bit counters, default half 3).
// The sync scenario runs only when CLOCK_DIV_MULTI_SYNC_EN is defined.
module tb_clock_div_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic [2:0]       en        = 3'b000;
    logic             cfg_valid = 1'b0;
    logic [1:0]       cfg_ch    = 2'd0;
    logic [CNT_W-1:0] cfg_half  = '0;
    logic             cfg_ready;
    logic [2:0]       div_clk;
    logic [2:0]       tick;
`ifdef CLOCK_DIV_MULTI_SYNC_EN
    logic             sync      = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    clock_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_HALF(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
`ifdef CLOCK_DIV_MULTI_SYNC_EN
        .sync     (sync),
`endif
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
        .div_clk  (div_clk),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        step(2);
        check("rst_div", 32'(div_clk), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h1);

        // Free run with H=3: first toggle on the third enabled edge.
        rst_n = 1'b1;
        en    = 3'b111;
        step(2);
        check("run_e2_div", 32'(div_clk), 32'h0);
        check("run_e2_tick", 32'(tick), 32'h0);
        step(1);
        check("run_e3_div", 32'(div_clk), 32'h7);
        check("run_e3_tick", 32'(tick), 32'h7);
        step(1);
        check("run_e4_tick", 32'(tick), 32'h0);
        check("run_e4_div", 32'(div_clk), 32'h7);
        step(2);
        check("run_e6_div", 32'(div_clk), 32'h0);
        check("run_e6_tick", 32'(tick), 32'h7);

        // Load ch0 half=5 at cnt=1; current half completes first.
        step(1);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd5;
        #1;
        check("ld0_ready_before", 32'(cfg_ready), 32'h1);
        step(1);
        cfg_valid = 1'b0;
        #1;
        check("ld0_ready_pending", 32'(cfg_ready), 32'h0);
        step(1);
        check("ld0_e9_div", 32'(div_clk), 32'h7);
        check("ld0_e9_tick", 32'(tick), 32'h7);
        check("ld0_ready_after", 32'(cfg_ready), 32'h1);
        step(3);
        check("ld0_e12_div", 32'(div_clk), 32'h1);
        check("ld0_e12_tick", 32'(tick), 32'h6);
        step(1);
        check("ld0_e13_tick", 32'(tick), 32'h0);
        step(1);
        check("ld0_e14_div", 32'(div_clk), 32'h0);
        check("ld0_e14_tick", 32'(tick), 32'h1);
        step(1);
        check("ld0_e15_div", 32'(div_clk), 32'h6);
        step(4);
        check("ld0_e19_div", 32'(div_clk), 32'h1);
        check("ld0_e19_tick", 32'(tick), 32'h1);

        // ch1 half=0 behaves as H=1: toggles every cycle, tick stays high.
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd0;
        step(1);
        cfg_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("h0_div1", 32'(div_clk[1]), 32'((k % 2) == 0));
            check("h0_tick1", 32'(tick[1]), 32'h1);
        end

        // Freeze ch2 at cnt=2 for 10 cycles, resume toggles on first enabled edge.
        step(2);
        en = 3'b011;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check("frz_tick2", 32'(tick[2]), 32'h0);
            check("frz_div2", 32'(div_clk[2]), 32'h0);
        end
        en = 3'b111;
        step(1);
        check("resume_div2", 32'(div_clk[2]), 32'h1);
        check("resume_tick2", 32'(tick[2]), 32'h1);

        // Out-of-range channel: ready, accepted, no effect.
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_half = 8'd7;
        #1;
        check("oor_ready", 32'(cfg_ready), 32'h1);
        step(1);
        cfg_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_ch = 2'(i);
            #1;
            check("oor_no_pend", 32'(cfg_ready), 32'h1);
        end
        step(2);
        check("oor_tick2", 32'(tick[2]), 32'h1);
        check("oor_div2", 32'(div_clk[2]), 32'h0);
        check("oor_tick1", 32'(tick[1]), 32'h1);

        // Reset mid-count with a pending load restores defaults everywhere.
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd7;
        step(1);
        cfg_valid = 1'b0;
        #1;
        check("rst2_pending", 32'(cfg_ready), 32'h0);
        step(1);
        rst_n = 1'b0;
        step(1);
        check("rst2_div", 32'(div_clk), 32'h0);
        check("rst2_tick", 32'(tick), 32'h0);
        check("rst2_ready", 32'(cfg_ready), 32'h1);
        rst_n = 1'b1;
        step(2);
        check("rst2_e2_div", 32'(div_clk), 32'h0);
        step(1);
        check("rst2_e3_div", 32'(div_clk), 32'h7);
        check("rst2_e3_tick", 32'(tick), 32'h7);
        step(3);
        check("rst2_e6_div", 32'(div_clk), 32'h0);
        check("rst2_e6_tick", 32'(tick), 32'h7);

`ifdef CLOCK_DIV_MULTI_SYNC_EN
        // Skew ch0 by 2 cycles, then realign with sync.
        en = 3'b110;
        step(2);
        en = 3'b111;
        step(2);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        check("sync_div", 32'(div_clk), 32'h0);
        check("sync_tick", 32'(tick), 32'h0);
        step(2);
        check("sync_e2_div", 32'(div_clk), 32'h0);
        step(1);
        check("sync_e3_div", 32'(div_clk), 32'h7);
        check("sync_e3_tick", 32'(tick), 32'h7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
